ram_arbiter: RTL and testbench
==============================

Name: ram_arbiter

Overview:
- Shares one single-port RAM (clk, wrEn, address, dataIn, dataOut) between N_CORES requesters in the multicore processor.
- Round-robin arbitration with a req/ack handshake.
- Registers the winning command onto the RAM port, collects the read data, and returns it to the winner with a one-cycle ack pulse.
- Sits between the core memory interfaces and the RAM instance.

Parameters:
- N_CORES, 4, number of requesters (>=2)
- WIDTH, 12, RAM data width
- DEPTH, 8, RAM words
- ADDR_WIDTH, $clog2(DEPTH), RAM address width

Ports:
- clk  input  1  system clock, all logic on posedge
- rst  input  1  synchronous, active-high reset
- req  input  N_CORES  per-core request, held high until that core's ack
- wrEn  input  N_CORES  per-core write enable, valid while req high
- address  input  N_CORES*ADDR_WIDTH  per-core address, core i at [i*ADDR_WIDTH +: ADDR_WIDTH]
- dataIn  input  N_CORES*WIDTH  per-core write data, core i at [i*WIDTH +: WIDTH]
- ack  output  N_CORES  one-hot, one-cycle completion pulse
- rdData  output  WIDTH  shared return data, valid while ack nonzero
- busy  output  1  high in every state except IDLE
- mem_wrEn  output  1  to RAM wrEn
- mem_address  output  ADDR_WIDTH  to RAM address
- mem_dataIn  output  WIDTH  to RAM dataIn
- mem_dataOut  input  WIDTH  from RAM dataOut

Behaviour:
- Reset (sync, rst high at posedge) sets:
  - state=IDLE, ack=0, rdData=0, busy=0
  - mem_wrEn=0, mem_address=0, mem_dataIn=0
  - last_grant=N_CORES-1, so core 0 has first priority.
- FSM states: IDLE -> ISSUE -> RESP -> IDLE. One access per 3 cycles maximum.
- IDLE:
  - eligible = req & ~ack; the core being acked this cycle is masked so its still-high req is not re-granted.
  - If eligible is nonzero, pick the first set bit searching last_grant+1, last_grant+2, ... with modulo N_CORES wrap.
  - At the posedge, register:
    - winner index
    - last_grant <= winner
    - mem_wrEn <= wrEn[winner]
    - mem_address <= address slice of the winner
    - mem_dataIn <= dataIn slice of the winner
  - Then go to ISSUE. Otherwise stay in IDLE with all mem_* outputs held and mem_wrEn=0.
- ISSUE: RAM port is driven for exactly one cycle; a write commits at the posedge ending ISSUE. At that posedge: mem_wrEn <= 0, go to RESP. mem_address is held through RESP.
- RESP: mem_dataOut is stable for mem_address, whether the RAM read is asynchronous or registered. At the posedge ending RESP:
  - rdData <= mem_dataOut for a read, or the written data for a write (write-through).
  - ack <= one-hot(winner), state <= IDLE.
- ack is high for exactly one cycle (the first IDLE cycle), then cleared.
- Latency: req sampled at edge t0 -> ack high during cycle t2..t3 (3 edges). rdData holds its value until the next ack.
- Requester rules:
  - Command fields must be stable from req rise until ack.
  - req must drop the cycle after ack unless a new command is presented.
  - A core may re-request immediately; it is eligible again from the second IDLE cycle.
- Fairness: with all cores requesting continuously, grants rotate 0,1,2,...,N_CORES-1,0. No core waits more than N_CORES-1 other grants.
- Simultaneous events: req changes on other cores during ISSUE/RESP are ignored until IDLE. Only one winner per arbitration.
- Reset mid-operation:
  - Reset asserted during ISSUE may still let the RAM commit that write at the same edge; no ack is ever generated for it.
  - Pending reqs are re-arbitrated after reset from core 0.
- No address range checks; ADDR_WIDTH covers DEPTH exactly.

Decomposition:
- Package ram_arbiter_pkg: state enum typedef (IDLE, ISSUE, RESP) and the default N_CORES/WIDTH/DEPTH constants shared with the core and RAM instances.
- One sub-module rr_arbiter: combinational round-robin picker.
  - Inputs: eligible[N_CORES], last_grant index.
  - Outputs: grant_valid, grant index.
  - Used by ram_arbiter in IDLE.

Test Plan:
- Reset behaviour: rst high 2 cycles with req=4'b1111 -> ack=0, busy=0, mem_wrEn=0 throughout. After release, the first grant goes to core 0.
- Single write then read: core 2 writes address 3, data 100 -> mem_wrEn high exactly 1 cycle with mem_address=3, mem_dataIn=100; ack=4'b0100 3 edges after req, rdData=100. Core 2 then reads address 3 -> ack=4'b0100, rdData=100.
- Round robin: all four cores request reads of addresses 0..3 (preloaded 10,20,30,40) and re-request after each ack -> ack order 0,1,2,3,0, rdData 10,20,30,40,10. No core is granted twice in a row while others are pending.
- Ack masking: core 1 alone holds req high one extra cycle after ack -> no second grant in that cycle; granted again only if req is still high in the following IDLE cycle.
- Reset mid-op: core 0 write to address 5, data 7 with rst asserted in ISSUE -> no ack, state IDLE next cycle. A subsequent read of address 5 by core 1 returns either the old value or 7, checked against the reference model.
- Random soak: 200 cycles of random req/wrEn/address/dataIn per core obeying the handshake rules -> every ack matches a scoreboard memory model, and every req is acked within 3*N_CORES+3 cycles.

Source files
------------

// File: rtl/ram_arbiter_pkg.sv
// Shared types and default sizing for the RAM arbiter and the core/RAM instances around it.
package ram_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RESP
  } state_t;

  localparam int unsigned N_CORES_DEF = 4;
  localparam int unsigned WIDTH_DEF   = 12;
  localparam int unsigned DEPTH_DEF   = 8;

endpackage

// File: rtl/ram_arbiter_if.sv
// Core-side request/ack bus of the RAM arbiter; per-core fields are packed side by side.
interface ram_arbiter_if
  import ram_arbiter_pkg::*;
#(
  parameter int unsigned N_CORES    = N_CORES_DEF,
  parameter int unsigned WIDTH      = WIDTH_DEF,
  parameter int unsigned ADDR_WIDTH = $clog2(DEPTH_DEF)
);
  logic [N_CORES-1:0]            req;
  logic [N_CORES-1:0]            wrEn;
  logic [N_CORES*ADDR_WIDTH-1:0] address;
  logic [N_CORES*WIDTH-1:0]      dataIn;
  logic [N_CORES-1:0]            ack;
  logic [WIDTH-1:0]              rdData;

  modport master (output req, wrEn, address, dataIn, input ack, rdData);
  modport slave  (input req, wrEn, address, dataIn, output ack, rdData);
endinterface

// File: rtl/ram_arbiter_rr.sv
// Combinational round-robin picker: first eligible index after last_grant, wrapping modulo N_CORES.
module rr_arbiter #(
  parameter int unsigned N_CORES = 4
) (
  input  logic [N_CORES-1:0]         eligible,
  input  logic [$clog2(N_CORES)-1:0] last_grant,
  output logic                       grant_valid,
  output logic [$clog2(N_CORES)-1:0] grant
);
  localparam int unsigned IDX_W = $clog2(N_CORES);

  // One spare bit so last_grant + offset never overflows before the wrap.
  logic [IDX_W:0] idx;

  always_comb begin
    grant_valid = 1'b0;
    grant       = '0;
    idx         = '0;
    for (int unsigned off = 1; off <= N_CORES; off++) begin
      idx = {1'b0, last_grant} + (IDX_W+1)'(off);
      if (idx >= (IDX_W+1)'(N_CORES)) begin
        idx = idx - (IDX_W+1)'(N_CORES);
      end
      if (!grant_valid && eligible[idx[IDX_W-1:0]]) begin
        grant_valid = 1'b1;
        grant       = idx[IDX_W-1:0];
      end
    end
  end
endmodule

// File: rtl/ram_arbiter.sv
// Shares one single-port RAM between N_CORES requesters: round-robin grant, one access per
// IDLE -> ISSUE -> RESP pass, registered RAM command and a one-cycle ack with the return data.
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int unsigned N_CORES    = N_CORES_DEF,
  parameter int unsigned WIDTH      = WIDTH_DEF,
  parameter int unsigned DEPTH      = DEPTH_DEF,
  parameter int unsigned ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  ram_arbiter_if.slave          cores,
  output logic                  busy,
  output logic                  mem_wrEn,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [WIDTH-1:0]      mem_dataIn,
  input  logic [WIDTH-1:0]      mem_dataOut
);
  localparam int unsigned IDX_W = $clog2(N_CORES);

  state_t             state, stateNext;
  logic [IDX_W-1:0]   winner, winnerNext;
  logic [IDX_W-1:0]   lastGrant, lastGrantNext;
  logic [IDX_W-1:0]   grant;
  logic               grantValid;
  logic               isWrite, isWriteNext;
  logic [N_CORES-1:0] ack, ackNext, eligible;
  logic [WIDTH-1:0]   rdData, rdDataNext;
  logic               wrEnNext;
  logic [ADDR_WIDTH-1:0] addressNext;
  logic [WIDTH-1:0]   dataInNext;

  // The core being acked still holds req this cycle; masking it stops an immediate re-grant.
  assign eligible = cores.req & ~ack;

  rr_arbiter #(.N_CORES(N_CORES)) u_rr (
    .eligible    (eligible),
    .last_grant  (lastGrant),
    .grant_valid (grantValid),
    .grant       (grant)
  );

  always_comb begin
    stateNext     = state;
    winnerNext    = winner;
    lastGrantNext = lastGrant;
    isWriteNext   = isWrite;
    ackNext       = '0;
    rdDataNext    = rdData;
    wrEnNext      = 1'b0;
    addressNext   = mem_address;
    dataInNext    = mem_dataIn;
    case (state)
      IDLE: begin
        if (grantValid) begin
          winnerNext    = grant;
          lastGrantNext = grant;
          isWriteNext   = cores.wrEn[grant];
          wrEnNext      = cores.wrEn[grant];
          addressNext   = cores.address[32'(grant)*ADDR_WIDTH +: ADDR_WIDTH];
          dataInNext    = cores.dataIn[32'(grant)*WIDTH +: WIDTH];
          stateNext     = ISSUE;
        end
      end
      ISSUE: stateNext = RESP;
      RESP: begin
        // Writes return the written word so every ack carries meaningful data.
        rdDataNext      = isWrite ? mem_dataIn : mem_dataOut;
        ackNext[winner] = 1'b1;
        stateNext       = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      winner      <= '0;
      lastGrant   <= IDX_W'(N_CORES - 1);
      isWrite     <= 1'b0;
      ack         <= '0;
      rdData      <= '0;
      mem_wrEn    <= 1'b0;
      mem_address <= '0;
      mem_dataIn  <= '0;
    end else begin
      state       <= stateNext;
      winner      <= winnerNext;
      lastGrant   <= lastGrantNext;
      isWrite     <= isWriteNext;
      ack         <= ackNext;
      rdData      <= rdDataNext;
      mem_wrEn    <= wrEnNext;
      mem_address <= addressNext;
      mem_dataIn  <= dataInNext;
    end
  end

  assign busy         = (state != IDLE);
  assign cores.ack    = ack;
  assign cores.rdData = rdData;
endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: vector table, directed corner sequences and a random soak scored
// against a plain memory model with write-through returns and a bounded wait per request.
module tb_ram_arbiter;
  localparam int NC    = 4;
  localparam int W     = 12;
  localparam int DEPTH = 8;
  localparam int AW    = 3;
  localparam int BOUND = 3*NC + 3;

  logic clk;
  logic rst;
  logic busy, memWrEn;
  logic [AW-1:0] memAddress;
  logic [W-1:0]  memDataIn, memDataOut;

  ram_arbiter_if #(.N_CORES(NC), .WIDTH(W), .ADDR_WIDTH(AW)) bus ();

  ram_arbiter #(.N_CORES(NC), .WIDTH(W), .DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
    .clk         (clk),
    .rst         (rst),
    .cores       (bus),
    .busy        (busy),
    .mem_wrEn    (memWrEn),
    .mem_address (memAddress),
    .mem_dataIn  (memDataIn),
    .mem_dataOut (memDataOut)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // RAM on the far side: asynchronous read, write on posedge whenever wrEn is high.
  logic [W-1:0] tbRam [DEPTH] = '{default: '0};
  always @(posedge clk) if (memWrEn) tbRam[memAddress] <= memDataIn;
  assign memDataOut = tbRam[memAddress];

  // Requester-side command registers.
  logic [NC-1:0] reqV = '0;
  logic [NC-1:0] cWr  = '0;
  logic [AW-1:0] cAddr [NC] = '{default: '0};
  logic [W-1:0]  cData [NC] = '{default: '0};
  int unsigned   reqEdge [NC] = '{default: 0};
  bit [NC-1:0]   timedOut = '0;
  int unsigned   edgeCnt = 0;

  always_comb begin
    for (int i = 0; i < NC; i++) begin
      bus.wrEn[i]             = cWr[i];
      bus.address[i*AW +: AW] = cAddr[i];
      bus.dataIn[i*W +: W]    = cData[i];
    end
    bus.req = reqV;
  end

  always @(posedge clk) edgeCnt <= edgeCnt + 1;

  int tests = 0;
  int fails = 0;
  logic [W-1:0] refMem [DEPTH] = '{default: '0};

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual %0d required %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Scoreboard: every ack must be one-hot, for a requesting core, carry the model's data
  // and arrive within the fairness bound.
  int monK;
  logic [W-1:0] monExp;
  always @(negedge clk) begin
    if (bus.ack != '0) begin
      check("ackOneHot", 32'($onehot(bus.ack)), 32'd1);
      monK = 0;
      for (int i = 0; i < NC; i++) if (bus.ack[i]) monK = i;
      check("ackHasReq", 32'(reqV[monK]), 32'd1);
      monExp = cWr[monK] ? cData[monK] : refMem[cAddr[monK]];
      if (cWr[monK]) refMem[cAddr[monK]] = cData[monK];
      check("sbData", 32'(bus.rdData), 32'(monExp));
      check("ackWithinBound", 32'(edgeCnt - reqEdge[monK] <= BOUND), 32'd1);
    end
    for (int i = 0; i < NC; i++) begin
      if (reqV[i] && !timedOut[i] && (edgeCnt - reqEdge[i] > BOUND)) begin
        timedOut[i] = 1'b1;
        tests++;
        fails++;
        $display("FAIL reqTimeout: core %0d waited %0d edges, required <= %0d", i, edgeCnt - reqEdge[i], BOUND);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic raise(input int k, input logic wr, input logic [AW-1:0] a, input logic [W-1:0] d);
    cWr[k]      = wr;
    cAddr[k]    = a;
    cData[k]    = d;
    reqV[k]     = 1'b1;
    reqEdge[k]  = edgeCnt;
    timedOut[k] = 1'b0;
  endtask

  task automatic waitAck(output logic [NC-1:0] ackV, output logic [W-1:0] rd, output int lat,
                         output int wrPulses, output logic [AW-1:0] wrAddr, output logic [W-1:0] wrData);
    ackV = '0; rd = '0; lat = -1; wrPulses = 0; wrAddr = '0; wrData = '0;
    for (int i = 1; i <= BOUND + 2; i++) begin
      tick();
      if (memWrEn) begin
        wrPulses++;
        wrAddr = memAddress;
        wrData = memDataIn;
      end
      if (bus.ack != '0) begin
        ackV = bus.ack;
        rd   = bus.rdData;
        lat  = i;
        break;
      end
    end
  endtask

  // Single transaction; req is held through the ack cycle and dropped the cycle after.
  task automatic doTxn(input int k, input logic wr, input logic [AW-1:0] a, input logic [W-1:0] d,
                       output logic [NC-1:0] ackV, output logic [W-1:0] rd, output int lat,
                       output int wrPulses, output logic [AW-1:0] wrAddr, output logic [W-1:0] wrData);
    raise(k, wr, a, d);
    waitAck(ackV, rd, lat, wrPulses, wrAddr, wrData);
    tick();
    reqV[k] = 1'b0;
  endtask

  typedef struct {
    int            core;
    logic          wr;
    logic [AW-1:0] addr;
    logic [W-1:0]  data;
    logic [NC-1:0] expAck;
    logic [W-1:0]  expRd;
  } vec_t;

  vec_t vecs [11];

  initial begin : main
    logic [NC-1:0] ackV;
    logic [W-1:0]  rd;
    int            lat, wrPulses, nAcks, cnt;
    logic [AW-1:0] wrAddr;
    logic [W-1:0]  wrData;
    logic [NC-1:0] pendingDrop;
    int            ackCores [$];
    logic [W-1:0]  ackData [$];
    int            expCores [5];
    logic [W-1:0]  expData [5];

    vecs[0]  = '{2, 1'b1, 3'd3, 12'd100,  4'b0100, 12'd100};
    vecs[1]  = '{2, 1'b0, 3'd3, 12'd0,    4'b0100, 12'd100};
    vecs[2]  = '{0, 1'b1, 3'd0, 12'd10,   4'b0001, 12'd10};
    vecs[3]  = '{1, 1'b1, 3'd1, 12'd20,   4'b0010, 12'd20};
    vecs[4]  = '{3, 1'b1, 3'd2, 12'd30,   4'b1000, 12'd30};
    vecs[5]  = '{2, 1'b1, 3'd3, 12'd40,   4'b0100, 12'd40};
    vecs[6]  = '{3, 1'b0, 3'd0, 12'd0,    4'b1000, 12'd10};
    vecs[7]  = '{1, 1'b0, 3'd2, 12'd0,    4'b0010, 12'd30};
    vecs[8]  = '{0, 1'b1, 3'd7, 12'hFFF,  4'b0001, 12'hFFF};
    vecs[9]  = '{3, 1'b0, 3'd7, 12'd0,    4'b1000, 12'hFFF};
    vecs[10] = '{0, 1'b0, 3'd3, 12'd0,    4'b0001, 12'd40};
    expCores = '{0, 1, 2, 3, 0};
    expData  = '{12'd10, 12'd20, 12'd30, 12'd40, 12'd10};

    rst = 1'b1;
    tick();
    tick();
    check("resetAck", 32'(bus.ack), 32'd0);
    check("resetRdData", 32'(bus.rdData), 32'd0);
    check("resetBusy", 32'(busy), 32'd0);
    check("resetMemAddr", 32'(memAddress), 32'd0);
    rst = 1'b0;

    // Vector table: isolated single-core transactions.
    foreach (vecs[v]) begin
      doTxn(vecs[v].core, vecs[v].wr, vecs[v].addr, vecs[v].data, ackV, rd, lat, wrPulses, wrAddr, wrData);
      check($sformatf("vec%0d_ack", v), 32'(ackV), 32'(vecs[v].expAck));
      check($sformatf("vec%0d_rdData", v), 32'(rd), 32'(vecs[v].expRd));
      check($sformatf("vec%0d_latency", v), 32'(lat), 32'd3);
      check($sformatf("vec%0d_wrPulses", v), 32'(wrPulses), vecs[v].wr ? 32'd1 : 32'd0);
      if (vecs[v].wr) begin
        check($sformatf("vec%0d_memAddr", v), 32'(wrAddr), 32'(vecs[v].addr));
        check($sformatf("vec%0d_memData", v), 32'(wrData), 32'(vecs[v].data));
      end
    end

    // Reset with every core requesting, then round-robin from core 0.
    rst = 1'b1;
    for (int k = 0; k < NC; k++) raise(k, 1'b0, AW'(k), '0);
    for (int c = 0; c < 2; c++) begin
      tick();
      check("rstHoldAck", 32'(bus.ack), 32'd0);
      check("rstHoldBusy", 32'(busy), 32'd0);
      check("rstHoldWrEn", 32'(memWrEn), 32'd0);
    end
    for (int k = 0; k < NC; k++) reqEdge[k] = edgeCnt;
    rst = 1'b0;
    pendingDrop = '0;
    nAcks = 0;
    for (int c = 0; c < 80 && (reqV != '0 || pendingDrop != '0); c++) begin
      tick();
      for (int k = 0; k < NC; k++) begin
        if (pendingDrop[k]) begin
          pendingDrop[k] = 1'b0;
          if (nAcks < 5) raise(k, 1'b0, AW'(k), '0);
          else reqV[k] = 1'b0;
        end
        if (bus.ack[k]) begin
          pendingDrop[k] = 1'b1;
          nAcks++;
          ackCores.push_back(k);
          ackData.push_back(bus.rdData);
        end
      end
    end
    check("rrAckCount", 32'(ackCores.size() >= 5), 32'd1);
    if (ackCores.size() > 0) check("firstGrantAfterReset", 32'(ackCores[0]), 32'd0);
    for (int i = 0; i < 5 && i < ackCores.size(); i++) begin
      check($sformatf("rrOrder%0d", i), 32'(ackCores[i]), 32'(expCores[i]));
      check($sformatf("rrData%0d", i), 32'(ackData[i]), 32'(expData[i]));
      if (i > 0) check($sformatf("rrNoRepeat%0d", i), 32'(ackCores[i] != ackCores[i-1]), 32'd1);
    end
    check("rrDrained", 32'(reqV), 32'd0);

    // Ack masking: req held only through the ack cycle gets no second grant.
    doTxn(1, 1'b0, 3'd1, '0, ackV, rd, lat, wrPulses, wrAddr, wrData);
    check("maskAck", 32'(ackV), 32'b0010);
    check("maskNoRegrant", 32'(busy), 32'd0);
    cnt = 0;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (busy || bus.ack != '0) cnt++;
    end
    check("maskStaysIdle", 32'(cnt), 32'd0);

    // Still high in the following IDLE cycle: granted again.
    raise(1, 1'b0, 3'd1, '0);
    waitAck(ackV, rd, lat, wrPulses, wrAddr, wrData);
    check("regrantFirstAck", 32'(ackV), 32'b0010);
    tick();
    check("regrantMaskedCycle", 32'(busy), 32'd0);
    raise(1, 1'b0, 3'd1, '0);
    tick();
    check("regrantFollowingIdle", 32'(busy), 32'd1);
    waitAck(ackV, rd, lat, wrPulses, wrAddr, wrData);
    check("regrantAck", 32'(ackV), 32'b0010);
    check("regrantData", 32'(rd), 32'd20);
    tick();
    reqV[1] = 1'b0;

    // Reset during ISSUE of a write: no ack; the RAM still sees wrEn at that edge.
    raise(0, 1'b1, 3'd5, 12'd7);
    tick();
    check("midIssueWrEn", 32'(memWrEn), 32'd1);
    check("midIssueAddr", 32'(memAddress), 32'd5);
    rst = 1'b1;
    reqV[0] = 1'b0;
    tick();
    check("midRstBusy", 32'(busy), 32'd0);
    check("midRstAck", 32'(bus.ack), 32'd0);
    rst = 1'b0;
    cnt = 0;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (bus.ack != '0) cnt++;
    end
    check("midRstNoAck", 32'(cnt), 32'd0);
    refMem[5] = 12'd7;
    doTxn(1, 1'b0, 3'd5, '0, ackV, rd, lat, wrPulses, wrAddr, wrData);
    check("midRstReadAck", 32'(ackV), 32'b0010);
    check("midRstReadData", 32'(rd), 32'd7);

    // Random soak obeying the handshake; the monitor scores every ack.
    pendingDrop = '0;
    for (int c = 0; c < 200; c++) begin
      tick();
      for (int k = 0; k < NC; k++) begin
        if (pendingDrop[k]) begin
          pendingDrop[k] = 1'b0;
          if ($urandom_range(1, 0) == 1)
            raise(k, 1'($urandom_range(1, 0)), AW'($urandom_range(DEPTH-1, 0)), W'($urandom));
          else
            reqV[k] = 1'b0;
        end else if (!reqV[k] && $urandom_range(2, 0) == 0) begin
          raise(k, 1'($urandom_range(1, 0)), AW'($urandom_range(DEPTH-1, 0)), W'($urandom));
        end
        if (bus.ack[k]) pendingDrop[k] = 1'b1;
      end
    end
    for (int c = 0; c < 60 && (reqV != '0 || pendingDrop != '0); c++) begin
      tick();
      for (int k = 0; k < NC; k++) begin
        if (pendingDrop[k]) begin
          pendingDrop[k] = 1'b0;
          reqV[k] = 1'b0;
        end
        if (bus.ack[k]) pendingDrop[k] = 1'b1;
      end
    end
    check("soakDrained", 32'(reqV), 32'd0);

    tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion before 200000");
    $fatal(1, "watchdog");
  end
endmodule
